// File: rtl/fifo_buffer_if.sv
// Purpose: handshake/status bundle between a FIFO producer/consumer (master)
//          and the fifo_buffer storage block (slave).
// Signals: write/read strobes and data_in driven by the master; data_out,
//          full, empty, count, overflow, underflow returned by the slave.
interface fifo_buffer_if #(
  parameter int unsigned FIFO_SIZE = 8,
  parameter int unsigned DATA_W    = 8
);
  localparam int unsigned CNT_W = $clog2(FIFO_SIZE + 1);

  logic              write;
  logic              read;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output write, read, data_in,
    input  data_out, full, empty, count, overflow, underflow
  );

  modport slave (
    input  write, read, data_in,
    output data_out, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_buffer.sv
// Purpose: single-clock FIFO, FIFO_SIZE words of DATA_W bits, registered read
//          data, occupancy count, full/empty status and one-cycle
//          overflow/underflow pulses for dropped accesses.
// Ports:   clk   - rising-edge clock
//          reset - asynchronous active-low reset
//          bus   - fifo_buffer_if.slave (strobes, data, status)
module fifo_buffer #(
  parameter int unsigned FIFO_SIZE = 8,
  parameter int unsigned DATA_W    = 8
) (
  input  logic         clk,
  input  logic         reset,
  fifo_buffer_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(FIFO_SIZE + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_SIZE);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_SIZE);

  logic [DATA_W-1:0] mem_q [FIFO_SIZE];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic full_c, empty_c, wr_acc_c, rd_acc_c;

  // Status decoded from the registered count only.
  assign full_c  = (count_q == CNT_FULL);
  assign empty_c = (count_q == '0);

  // A full FIFO still takes a write when a read frees a slot the same edge;
  // an empty FIFO never bypasses write data to the read side.
  assign wr_acc_c = bus.write && (!full_c || bus.read);
  assign rd_acc_c = bus.read && !empty_c;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state computation.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (wr_acc_c) wptr_d = ptr_next(wptr_q);
    if (rd_acc_c) begin
      rptr_d     = ptr_next(rptr_q);
      data_out_d = mem_q[rptr_q];
    end

    unique case ({wr_acc_c, rd_acc_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    overflow_d  = bus.write && !wr_acc_c;
    underflow_d = bus.read && !rd_acc_c;
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset && wr_acc_c) mem_q[wptr_q] <= bus.data_in;
  end

  assign bus.data_out  = data_out_q;
  assign bus.count     = count_q;
  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fifo_buffer.sv
// Purpose: directed self-checking bench for fifo_buffer (FIFO_SIZE=8, DATA_W=8).
module tb_fifo_buffer;
  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  fifo_buffer_if #(.FIFO_SIZE(8), .DATA_W(8)) bus ();

  fifo_buffer #(.FIFO_SIZE(8), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    bus.write   = w;
    bus.read    = r;
    bus.data_in = d;
  endtask

  task automatic chk_status(input string tag, input int cnt, input logic fl, input logic em);
    chk({tag, "_count"}, 32'(bus.count), 32'(cnt));
    chk({tag, "_full"},  32'(bus.full),  32'(fl));
    chk({tag, "_empty"}, 32'(bus.empty), 32'(em));
  endtask

  logic [7:0] v4  [4] = '{8'hFF, 8'h00, 8'hF0, 8'h0F};
  logic [7:0] v8  [8] = '{8'hFF, 8'h00, 8'hF0, 8'h0F, 8'h55, 8'h6C, 8'h10, 8'h01};
  logic [7:0] v8b [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Reset then idle
    chk_status("rst", 0, 1'b0, 1'b1);
    chk("rst_dout", 32'(bus.data_out), 32'h00);
    chk("rst_ovf",  32'(bus.overflow), 32'h0);
    chk("rst_unf",  32'(bus.underflow), 32'h0);

    // Four writes then five reads
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, v4[i]);
      tick();
      chk("w4_count", 32'(bus.count), 32'(i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      tick();
      chk("r4_dout", 32'(bus.data_out), 32'(v4[i]));
      chk("r4_unf", 32'(bus.underflow), 32'h0);
    end
    tick();
    chk("r5_unf",  32'(bus.underflow), 32'h1);
    chk("r5_dout", 32'(bus.data_out), 32'h0F);
    chk_status("r5", 0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    chk("unf_pulse_end", 32'(bus.underflow), 32'h0);

    // Fill to full, rejected ninth write, drain
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, v8[i]);
      tick();
    end
    chk_status("fill8", 8, 1'b1, 1'b0);
    chk("fill8_ovf", 32'(bus.overflow), 32'h0);
    drive(1'b1, 1'b0, 8'h81);
    tick();
    chk("ovf_flag", 32'(bus.overflow), 32'h1);
    chk_status("ovf", 8, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    chk("ovf_pulse_end", 32'(bus.overflow), 32'h0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      tick();
      chk("drain8_dout", 32'(bus.data_out), 32'(v8[i]));
    end
    chk_status("drain8", 0, 1'b0, 1'b1);
    chk("drain8_unf", 32'(bus.underflow), 32'h0);

    // Simultaneous read+write while full
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, v8b[i]);
      tick();
    end
    drive(1'b1, 1'b1, 8'h01);
    tick();
    chk("rwfull_dout", 32'(bus.data_out), 32'h11);
    chk("rwfull_ovf",  32'(bus.overflow), 32'h0);
    chk_status("rwfull", 8, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      tick();
      chk("rwfull_drain", 32'(bus.data_out), 32'(v8b[i]));
    end
    tick();
    chk("rwfull_last", 32'(bus.data_out), 32'h01);
    chk_status("rwfull_end", 0, 1'b0, 1'b1);

    // Simultaneous read+write while empty
    drive(1'b1, 1'b1, 8'hAA);
    tick();
    chk("rwempty_unf",  32'(bus.underflow), 32'h1);
    chk("rwempty_dout", 32'(bus.data_out), 32'h01);
    chk_status("rwempty", 1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h00);
    tick();
    chk("rwempty_rd", 32'(bus.data_out), 32'hAA);
    chk("rwempty_unf2", 32'(bus.underflow), 32'h0);
    chk_status("rwempty_end", 0, 1'b0, 1'b1);

    // Asynchronous reset mid-burst
    drive(1'b1, 1'b0, 8'h31); tick();
    drive(1'b1, 1'b0, 8'h32); tick();
    drive(1'b1, 1'b0, 8'h33); tick();
    chk("burst_count", 32'(bus.count), 32'd3);
    drive(1'b1, 1'b0, 8'h34);
    #2;
    reset = 1'b0;
    #1;
    chk_status("arst", 0, 1'b0, 1'b1);
    chk("arst_dout", 32'(bus.data_out), 32'h00);
    tick();
    chk("arst_hold_count", 32'(bus.count), 32'd0);
    chk("arst_hold_ovf", 32'(bus.overflow), 32'h0);
    drive(1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'hC1); tick();
    drive(1'b1, 1'b0, 8'hC2); tick();
    chk("post_count", 32'(bus.count), 32'd2);
    drive(1'b0, 1'b1, 8'h00); tick();
    chk("post_rd1", 32'(bus.data_out), 32'hC1);
    tick();
    chk("post_rd2", 32'(bus.data_out), 32'hC2);
    chk_status("post_end", 0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 8'h00);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
